// File: rtl/fb_stream_reader.sv
// fb_stream_reader: framebuffer read side for the OLED path.
// On an accepted start pulse, walks BRAM addresses BASE_ADDR .. BASE_ADDR+FRAME_BYTES-1
// and streams one byte per address over a valid/ready interface. A 2-entry prefetch
// buffer hides the 1-cycle BRAM latency, so a consumer holding m_ready high gets one
// byte per clock.
//
// Optional feature macro: FB_INVERT_EN
//   When defined, adds the `invert` input. It is latched when start is accepted and
//   applies to the whole frame: every streamed byte is bitwise inverted.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 1-cycle frame request (ignored while busy)
//   invert                (FB_INVERT_EN only) invert the frame's bytes
//   busy                  frame in progress
//   done                  1-cycle pulse after the final byte handshake
//   mem_addr, mem_we      BRAM address; write enable tied low
//   mem_dout              BRAM read data (one cycle after the address)
//   m_valid/m_ready       stream handshake
//   m_data, m_last        stream byte; last-byte marker
module fb_stream_reader #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FRAME_BYTES = 1024,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
`ifdef FB_INVERT_EN
  input  logic                  invert,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int unsigned CNT_W = $clog2(FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0]      FRAME_CNT = CNT_W'(FRAME_BYTES);
  localparam logic [CNT_W-1:0]      LAST_IDX  = CNT_W'(FRAME_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  inflight_q, inflight_d;
  logic                  head_valid_q, head_valid_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic                  head_last_q, head_last_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  accept_c;
  logic                  pop_c;
  logic                  last_pop_c;
  logic                  head_keep_c;
  logic [1:0]            occ_c;
  logic                  issue_c;
  logic [DATA_WIDTH-1:0] cap_data_c;

`ifdef FB_INVERT_EN
  logic invert_q, invert_d;
  assign cap_data_c = mem_dout ^ {DATA_WIDTH{invert_q}};
`else
  assign cap_data_c = mem_dout;
`endif

  // Handshake and read-issue qualifiers.
  // Occupancy counts what remains after this cycle's pop, so a held-ready consumer
  // can pop, capture and issue in the same cycle with no bubble.
  assign accept_c    = (state_q == S_IDLE) && start;
  assign pop_c       = head_valid_q && m_ready;
  assign last_pop_c  = pop_c && (out_cnt_q == LAST_IDX);
  assign head_keep_c = head_valid_q && !pop_c;
  assign occ_c       = 2'(head_valid_q) + 2'(skid_valid_q) + 2'(inflight_q) - 2'(pop_c);
  assign issue_c     = (state_q == S_STREAM) && (rd_cnt_q < FRAME_CNT) && (occ_c < 2'd2);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_STREAM;
      S_STREAM: if (rd_cnt_q == FRAME_CNT) state_d = S_DRAIN;
      S_DRAIN:  if (last_pop_c) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Counters, address lookahead and prefetch buffer.
  always_comb begin
    rd_cnt_d     = rd_cnt_q;
    out_cnt_d    = out_cnt_q;
    addr_d       = addr_q;
    inflight_d   = issue_c;
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_q == S_DRAIN) && last_pop_c;
`ifdef FB_INVERT_EN
    invert_d     = invert_q;
`endif

    if (accept_c) begin
      rd_cnt_d  = '0;
      out_cnt_d = '0;
      addr_d    = BASE;
`ifdef FB_INVERT_EN
      invert_d  = invert;
`endif
    end

    // mem_addr always shows the next address to read; it clamps at the final
    // address instead of running past the frame.
    if (issue_c) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
      if ((rd_cnt_q + CNT_W'(1)) < FRAME_CNT) begin
        addr_d = BASE + ADDR_WIDTH'(rd_cnt_q + CNT_W'(1));
      end
    end

    if (pop_c) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end

    // Head entry drives the stream outputs; skid holds the second prefetched byte.
    if (!head_keep_c) begin
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_data_d  = skid_data_q;
        skid_valid_d = inflight_q;
        skid_data_d  = cap_data_c;
      end else begin
        head_valid_d = inflight_q;
        if (inflight_q) head_data_d = cap_data_c;
      end
    end else if (inflight_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = cap_data_c;
    end

    head_last_d = head_valid_d && (out_cnt_d == LAST_IDX);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q     <= '0;
      out_cnt_q    <= '0;
      addr_q       <= BASE;
      inflight_q   <= 1'b0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
      head_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef FB_INVERT_EN
      invert_q     <= 1'b0;
`endif
    end else begin
      rd_cnt_q     <= rd_cnt_d;
      out_cnt_q    <= out_cnt_d;
      addr_q       <= addr_d;
      inflight_q   <= inflight_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
      head_last_q  <= head_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef FB_INVERT_EN
      invert_q     <= invert_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_addr = addr_q;
  assign mem_we   = 1'b0;
  assign m_valid  = head_valid_q;
  assign m_data   = head_data_q;
  assign m_last   = head_last_q;

endmodule

// File: tb/tb_fb_stream_reader.sv
// Testbench for fb_stream_reader: two instances (BASE_ADDR 0x000 and 0xFF0, 16-byte
// frames) share stimulus; a behavioural frame model predicts busy/done, byte order,
// last marker, first-valid latency, stall stability and the address window.
module tb_fb_stream_reader;

  localparam int F = 16;
  localparam logic [11:0] BASE0 = 12'h000;
  localparam logic [11:0] BASE1 = 12'hFF0;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic m_ready;
`ifdef FB_INVERT_EN
  logic invert;
`endif

  logic        busy     [2];
  logic        done     [2];
  logic        mem_we   [2];
  logic        m_valid  [2];
  logic        m_last   [2];
  logic [11:0] mem_addr [2];
  logic [7:0]  mem_dout [2];
  logic [7:0]  m_data   [2];
  logic [7:0]  bram     [4096];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fb_stream_reader #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .FRAME_BYTES(F), .BASE_ADDR(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef FB_INVERT_EN
    .invert(invert),
`endif
    .busy(busy[0]), .done(done[0]), .mem_addr(mem_addr[0]), .mem_we(mem_we[0]),
    .mem_dout(mem_dout[0]), .m_valid(m_valid[0]), .m_ready(m_ready),
    .m_data(m_data[0]), .m_last(m_last[0])
  );

  fb_stream_reader #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .FRAME_BYTES(F), .BASE_ADDR(12'hFF0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef FB_INVERT_EN
    .invert(invert),
`endif
    .busy(busy[1]), .done(done[1]), .mem_addr(mem_addr[1]), .mem_we(mem_we[1]),
    .mem_dout(mem_dout[1]), .m_valid(m_valid[1]), .m_ready(m_ready),
    .m_data(m_data[1]), .m_last(m_last[1])
  );

  // Synchronous-read BRAMs, preloaded with mem[a] = a[7:0].
  always @(posedge clk) begin
    mem_dout[0] <= bram[mem_addr[0]];
    mem_dout[1] <= bram[mem_addr[1]];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] base_of(input int k);
    return (k == 0) ? BASE0 : BASE1;
  endfunction

  // Reference model state, one set per instance.
  bit         busy_e   [2];
  bit         done_e   [2];
  bit         inv_e    [2];
  bit         stall_p  [2];
  logic [7:0] data_p   [2];
  int         idx_e    [2];
  int         lat_e    [2];
  int         first_c  [2];
  int         gap_e    [2];
  int         frames_e [2];
  int         cyc = 0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      busy_e[k] = 0; done_e[k] = 0; inv_e[k] = 0; stall_p[k] = 0; data_p[k] = '0;
      idx_e[k] = 0; lat_e[k] = 3; first_c[k] = 0; gap_e[k] = 0; frames_e[k] = 0;
    end
  end

  // Monitor: compare this cycle against the model, then advance the model.
  always @(negedge clk) begin
    bit         hs;
    bit         was_busy;
    int         off;
    logic [7:0] exp_b;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        busy_e[k] = 0; done_e[k] = 0; idx_e[k] = 0; lat_e[k] = 3; stall_p[k] = 0;
      end else begin
        was_busy = busy_e[k];
        chk("busy", 32'(busy[k]), 32'(busy_e[k]));
        chk("done", 32'(done[k]), 32'(done_e[k]));
        chk("mem_we", 32'(mem_we[k]), 32'(0));
        off = int'(12'(mem_addr[k] - base_of(k)));
        chk("addr_window", 32'(off <= F - 1), 32'(1));
        if (busy_e[k]) chk("read_ahead", 32'(off <= idx_e[k] + 2), 32'(1));
        if (lat_e[k] < 3) begin
          chk("first_valid_latency", 32'(m_valid[k]), 32'(lat_e[k] == 2));
          lat_e[k]++;
        end
        if (stall_p[k]) begin
          chk("stall_valid", 32'(m_valid[k]), 32'(1));
          chk("stall_data", 32'(m_data[k]), 32'(data_p[k]));
        end
        chk("m_last", 32'(m_last[k]), 32'(m_valid[k] && (idx_e[k] == F - 1)));

        hs = m_valid[k] && m_ready;
        done_e[k] = 0;
        if (hs) begin
          chk("beat_in_frame", 32'(busy_e[k]), 32'(1));
          exp_b = 8'(base_of(k) + 12'(idx_e[k])) ^ {8{inv_e[k]}};
          chk("data", 32'(m_data[k]), 32'(exp_b));
          if (idx_e[k] == 0) first_c[k] = cyc;
          if (idx_e[k] == F - 1) begin
            done_e[k] = 1;
            busy_e[k] = 0;
            gap_e[k] = cyc - first_c[k];
            frames_e[k]++;
            idx_e[k] = 0;
          end else begin
            idx_e[k]++;
          end
        end
        if (!was_busy && start) begin
          busy_e[k] = 1;
          idx_e[k] = 0;
          lat_e[k] = 0;
`ifdef FB_INVERT_EN
          inv_e[k] = invert;
`else
          inv_e[k] = 0;
`endif
        end
        stall_p[k] = m_valid[k] && !m_ready;
        data_p[k] = m_data[k];
      end
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  int mode = 0;
  int pat = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    case (mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ((pat % 3) == 0);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    pat++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_e[0] || busy_e[1]) && n < 2000) begin
      tick();
      n++;
    end
    chk("frame_timeout", 32'(busy_e[0] || busy_e[1]), 32'(0));
    tick();
  endtask

  int frames_exp = 0;

  initial begin
    for (int a = 0; a < 4096; a++) bram[a] = 8'(a);
    rst_n = 1'b0;
    start = 1'b0;
    m_ready = 1'b1;
`ifdef FB_INVERT_EN
    invert = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", 32'(busy[k]), 32'(0));
      chk("rst_done", 32'(done[k]), 32'(0));
      chk("rst_valid", 32'(m_valid[k]), 32'(0));
      chk("rst_last", 32'(m_last[k]), 32'(0));
      chk("rst_data", 32'(m_data[k]), 32'(0));
      chk("rst_addr", 32'(mem_addr[k]), 32'(base_of(k)));
      chk("rst_we", 32'(mem_we[k]), 32'(0));
    end
    rst_n = 1'b1;
    tick();

    // Held-ready frame: 16 consecutive beats.
    mode = 0;
    pulse_start();
    wait_idle();
    frames_exp++;
    chk("burst_gap0", 32'(gap_e[0]), 32'(F - 1));
    chk("burst_gap1", 32'(gap_e[1]), 32'(F - 1));

    // Ready pattern 1,0,0 repeating.
    mode = 1;
    pat = 0;
    pulse_start();
    wait_idle();
    frames_exp++;

    // Random ready with a second start mid-frame (ignored).
    mode = 2;
    pulse_start();
    repeat (6) tick();
    pulse_start();
    wait_idle();
    frames_exp++;

    // Back-to-back: start in the done cycle.
    mode = 0;
    pulse_start();
    begin
      int n = 0;
      while (!done_e[0] && n < 500) begin
        tick();
        n++;
      end
      chk("done_wait", 32'(done_e[0]), 32'(1));
    end
    pulse_start();
    chk("b2b_accepted", 32'(busy_e[0] && busy_e[1]), 32'(1));
    wait_idle();
    frames_exp += 2;
    chk("b2b_gap", 32'(gap_e[0]), 32'(F - 1));

`ifdef FB_INVERT_EN
    // Invert latched at start; later change ignored.
    invert = 1'b1;
    pulse_start();
    repeat (4) tick();
    invert = 1'b0;
    wait_idle();
    frames_exp++;
`endif

    // Asynchronous reset after 5 beats aborts the frame.
    mode = 0;
    pulse_start();
    begin
      int n = 0;
      while (idx_e[0] != 5 && n < 500) begin
        tick();
        n++;
      end
      chk("beat5_wait", 32'(idx_e[0]), 32'(5));
    end
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_valid", 32'(m_valid[k]), 32'(0));
      chk("arst_busy", 32'(busy[k]), 32'(0));
      chk("arst_done", 32'(done[k]), 32'(0));
    end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    wait_idle();
    frames_exp++;

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      mode = 2;
`ifdef FB_INVERT_EN
      invert = 1'($urandom_range(0, 1));
`endif
      pulse_start();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 10)) tick();
        pulse_start();
      end
      wait_idle();
      frames_exp++;
    end

    chk("frames0", 32'(frames_e[0]), 32'(frames_exp));
    chk("frames1", 32'(frames_e[1]), 32'(frames_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
